// File: rtl/seg_scan_driver_if.sv
// Display-driver bus: scan control and shadow-load inputs, segment/digit-enable outputs.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     dp_mask;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, load, value, blank_mask, dp_mask,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, load, value, blank_mask, dp_mask,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner; outputs registered, lag idx by 1 cycle, no backpressure.
// Optional leading-zero blanking when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int   PW      = $clog2(CLK_DIV);
  localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_blank;
  logic [DIGITS-1:0]   shadow_dp;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_q;

  logic                tick;
  logic                idx_last;
  logic [3:0]          nib;
  logic                mask_blk;
  logic                any_blk;
  logic                dp_sel;
  logic [6:0]          code;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   auto_blank;

  assign tick     = bus.en && (presc == PW'(CLK_DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is auto-blanked while it and every digit above it are zero; digit 0 always shows.
  always_comb begin : lz_blank
    logic zero_run;
    zero_run   = 1'b1;
    auto_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (shadow_val[4*i +: 4] == 4'h0);
      auto_blank[i] = zero_run;
    end
  end
`else
  assign auto_blank = '0;
`endif

  always_comb begin
    nib      = 4'h0;
    mask_blk = 1'b0;
    any_blk  = 1'b0;
    dp_sel   = 1'b0;
    onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = shadow_val[4*i +: 4];
        mask_blk  = shadow_blank[i];
        any_blk   = shadow_blank[i] | auto_blank[i];
        dp_sel    = shadow_dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    code = 7'b0000000;
    case (nib)
      4'h0: code = 7'b0111111;
      4'h1: code = 7'b0011000;
      4'h2: code = 7'b1110110;
      4'h3: code = 7'b1111100;
      4'h4: code = 7'b1011001;
      4'h5: code = 7'b1101101;
      4'h6: code = 7'b1101111;
      4'h7: code = 7'b0111000;
      4'h8: code = 7'b1111111;
      4'h9: code = 7'b1111001;
      4'hA: code = 7'b1111011;
      4'hB: code = 7'b1001111;
      4'hC: code = 7'b0100111;
      4'hD: code = 7'b1011110;
      4'hE: code = 7'b1100111;
      4'hF: code = 7'b1100011;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      seg_q        <= {7{SEG_INV}};
      dp_q         <= SEG_INV;
      an_q         <= {DIGITS{AN_INV}};
      frame_q      <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_val   <= bus.value;
        shadow_blank <= bus.blank_mask;
        shadow_dp    <= bus.dp_mask;
      end
      if (bus.en) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) idx <= idx_last ? '0 : idx + IW'(1);
        seg_q <= (any_blk ? 7'b0000000 : code) ^ {7{SEG_INV}};
        // Auto-blanked digits keep their decimal point; only the mask kills it.
        dp_q  <= (dp_sel & ~mask_blk) ^ SEG_INV;
        an_q  <= onehot ^ {DIGITS{AN_INV}};
      end else begin
        seg_q <= {7{SEG_INV}};
        dp_q  <= SEG_INV;
        an_q  <= {DIGITS{AN_INV}};
      end
      frame_q <= tick && idx_last;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, CLK_DIV=4, active-high segments, active-low anodes.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  seg_scan_driver_if #(.DIGITS(4)) bus ();

  seg_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0011000;
      4'h2: return 7'b1110110;  4'h3: return 7'b1111100;
      4'h4: return 7'b1011001;  4'h5: return 7'b1101101;
      4'h6: return 7'b1101111;  4'h7: return 7'b0111000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111001;
      4'hA: return 7'b1111011;  4'hB: return 7'b1001111;
      4'hC: return 7'b0100111;  4'hD: return 7'b1011110;
      4'hE: return 7'b1100111;  default: return 7'b1100011;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int d);
    case (d)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    @(negedge clk);
    bus.value = v; bus.blank_mask = b; bus.dp_mask = d; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Returns on the negedge where frame_done is seen; display still shows digit 3 there.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.en = 1'b1; bus.load = 1'b0;
    bus.value = '0; bus.blank_mask = '0; bus.dp_mask = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
    checks++; if (bus.seg !== 7'b0000000) begin errors++; $display("FAIL reset_seg got=%b exp=0000000", bus.seg); end
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL reset_dp got=%b exp=0", bus.dp); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", bus.frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL release_an got=%b exp=1110", bus.an); end
    checks++; if (bus.seg !== 7'b0111111) begin errors++; $display("FAIL release_seg got=%b exp=0111111", bus.seg); end
  endtask

  task automatic test_scan;
    bit ok;
    logic [15:0] v;
    logic [11:0] got, exp;
    v = 16'h1234;
    do_load(v, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_frame_timeout got=0 exp=1"); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      got = {bus.an, bus.seg, bus.dp};
      exp = {exp_an(k / 4), exp_code(v[4*(k/4) +: 4]), 1'b0};
      checks++; if (got !== exp) begin errors++; $display("FAIL scan_k%0d got=%b exp=%b", k, got, exp); end
      checks++; if (bus.frame_done !== (k == 15)) begin errors++; $display("FAIL scan_fd_k%0d got=%b exp=%b", k, bus.frame_done, (k == 15)); end
    end
  endtask

  task automatic test_decode_sweep;
    bit ok;
    logic [3:0] n;
    logic [6:0] exp;
    for (int i = 0; i < 16; i++) begin
      n = 4'(i);
      do_load({4{n}}, 4'b0000, 4'b0000);
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sweep_frame_timeout_%0d got=0 exp=1", i); end
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k % 4 == 0) begin
          exp = exp_code(n);
`ifdef SEG_LEADING_ZERO_BLANK_EN
          if (n == 4'h0 && k != 0) exp = 7'b0000000;
`endif
          checks++; if (bus.seg !== exp) begin errors++; $display("FAIL sweep_%h_d%0d got=%b exp=%b", n, k / 4, bus.seg, exp); end
        end
      end
    end
  endtask

  task automatic test_blank_dp;
    bit ok;
    logic [6:0] es [4];
    logic       ed [4];
    es[0] = 7'b1111111; es[1] = 7'b1111111; es[2] = 7'b0000000; es[3] = 7'b1111111;
    ed[0] = 1'b1;       ed[1] = 1'b0;       ed[2] = 1'b0;       ed[3] = 1'b0;
    do_load(16'h8888, 4'b0100, 4'b0001);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL blank_frame_timeout got=0 exp=1"); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 1) begin
        checks++; if ({bus.an, bus.seg, bus.dp} !== {exp_an(k / 4), es[k/4], ed[k/4]})
          begin errors++; $display("FAIL blank_d%0d got=%b/%b/%b exp=%b/%b/%b", k / 4,
            bus.an, bus.seg, bus.dp, exp_an(k / 4), es[k/4], ed[k/4]); end
      end
    end
  endtask

  task automatic test_freeze;
    bit ok;
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL freeze_frame_timeout got=0 exp=1"); end
    repeat (10) @(negedge clk);
    checks++; if (bus.an !== 4'b1011) begin errors++; $display("FAIL freeze_pre_an got=%b exp=1011", bus.an); end
    bus.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'b0000000, 1'b0, 1'b0})
        begin errors++; $display("FAIL freeze_dark_c%0d got=%b/%b/%b/%b exp=1111/0000000/0/0", c,
          bus.an, bus.seg, bus.dp, bus.frame_done); end
      bus.load  = (c == 4);
      bus.value = 16'h5678;
    end
    bus.en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({bus.an, bus.seg} !== {4'b1011, 7'b1101111})
        begin errors++; $display("FAIL resume_d2_c%0d got=%b/%b exp=1011/1101111", c, bus.an, bus.seg); end
    end
    @(negedge clk);
    checks++; if ({bus.an, bus.seg} !== {4'b0111, 7'b1101101})
      begin errors++; $display("FAIL resume_d3 got=%b/%b exp=0111/1101101", bus.an, bus.seg); end
    repeat (2) @(negedge clk);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL resume_fd_early got=%b exp=0", bus.frame_done); end
    @(negedge clk);
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL resume_fd got=%b exp=1", bus.frame_done); end
    @(negedge clk);
    checks++; if ({bus.an, bus.seg} !== {4'b1110, 7'b1111111})
      begin errors++; $display("FAIL resume_d0 got=%b/%b exp=1110/1111111", bus.an, bus.seg); end
  endtask

  task automatic test_leading_zero;
    bit ok;
    logic [6:0] es [4];
    logic       ed [4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    es[0] = 7'b0111111; es[1] = 7'b1101101; es[2] = 7'b0000000; es[3] = 7'b0000000;
`else
    es[0] = 7'b0111111; es[1] = 7'b1101101; es[2] = 7'b0111111; es[3] = 7'b0111111;
`endif
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lz_frame_timeout got=0 exp=1"); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 2) begin
        checks++; if (bus.seg !== es[k/4]) begin errors++; $display("FAIL lz50_d%0d got=%b exp=%b", k / 4, bus.seg, es[k/4]); end
      end
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    es[1] = 7'b0000000;
`else
    es[1] = 7'b0111111;
`endif
    ed[0] = 1'b0; ed[1] = 1'b0; ed[2] = 1'b0; ed[3] = 1'b1;
    do_load(16'h0000, 4'b0000, 4'b1000);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lz0_frame_timeout got=0 exp=1"); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 2) begin
        checks++; if ({bus.seg, bus.dp} !== {es[k/4], ed[k/4]})
          begin errors++; $display("FAIL lz0_d%0d got=%b/%b exp=%b/%b", k / 4, bus.seg, bus.dp, es[k/4], ed[k/4]); end
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    do_load(16'hABCD, 4'b0000, 4'b1111);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_frame_timeout got=0 exp=1"); end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'b0000000, 1'b0, 1'b0})
      begin errors++; $display("FAIL rstmid_state got=%b/%b/%b/%b exp=1111/0000000/0/0",
        bus.an, bus.seg, bus.dp, bus.frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.an, bus.seg, bus.dp} !== {4'b1110, 7'b0111111, 1'b0})
      begin errors++; $display("FAIL rstmid_release got=%b/%b/%b exp=1110/0111111/0", bus.an, bus.seg, bus.dp); end
    repeat (3) @(negedge clk);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL rstmid_hold got=%b exp=1110", bus.an); end
    @(negedge clk);
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("FAIL rstmid_next got=%b exp=1101", bus.an); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan();
    test_decode_sweep();
    test_blank_dp();
    test_freeze();
    test_leading_zero();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
